// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues one req/ready handshake per access,
// stalls the pipeline while it is in flight, and reports misalignment and timeouts.
module dmem_access_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              Enable_In,
   input  logic              rw_In,
   input  logic              Size_In,
   input  logic              Load_In,
   input  logic [ADDR_W-1:0] Address_In,
   input  logic [DATA_W-1:0] WData_In,
   output logic              mem_req,
   output logic              mem_rw,
   output logic              mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              Stall_Out,
   output logic              Done_Out,
   output logic              Load_Out,
   output logic [DATA_W-1:0] RData_Out,
   output logic              Error_Out
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic              rw_q, rw_d;
   logic              size_q, size_d;
   logic              load_q, load_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              tmo_q, tmo_d;
   logic              mis_q, mis_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              aligned;
   logic              stall;

   assign aligned = Size_In | (Address_In[1:0] == 2'b00);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rw_d    = rw_q;
      size_d  = size_q;
      load_d  = load_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      tmo_d   = tmo_q;
      cnt_d   = cnt_q;
      mis_d   = 1'b0;
      stall   = 1'b0;
      case (state_q)
         StIdle: begin
            if (Enable_In) begin
               if (aligned) begin
                  rw_d    = rw_In;
                  size_d  = Size_In;
                  load_d  = Load_In;
                  addr_d  = Address_In;
                  wdata_d = WData_In;
                  req_d   = 1'b1;
                  cnt_d   = '0;
                  tmo_d   = 1'b0;
                  stall   = 1'b1;
                  state_d = StBusy;
               end else begin
                  mis_d = 1'b1;
               end
            end
         end
         StBusy: begin
            stall = 1'b1;
            if (cnt_q != CntW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
            // ready takes priority over a timeout in the same cycle
            if (mem_ready) begin
               if (rw_q)        rdata_d = '0;
               else if (size_q) rdata_d = DATA_W'(mem_rdata[7:0]);
               else             rdata_d = mem_rdata;
               req_d   = 1'b0;
               state_d = StDone;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               tmo_d   = 1'b1;
               rdata_d = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         rw_q    <= 1'b0;
         size_q  <= 1'b0;
         load_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         tmo_q   <= 1'b0;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rw_q    <= rw_d;
         size_q  <= size_d;
         load_q  <= load_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         tmo_q   <= tmo_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_req   = req_q;
   assign mem_rw    = rw_q;
   assign mem_size  = size_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign Stall_Out = stall;
   assign Done_Out  = (state_q == StDone);
   assign Load_Out  = Done_Out & load_q & ~tmo_q;
   assign RData_Out = rdata_q;
   assign Error_Out = mis_q | (Done_Out & tmo_q);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: completions are queued at issue and checked
// when Done_Out or Error_Out appears; handshake timing is checked per access.
module tb_dmem_access_ctrl;

   logic        CLK, CLR;
   logic        Enable_In, rw_In, Size_In, Load_In;
   logic [31:0] Address_In, WData_In;
   logic        mem_req, mem_rw, mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic        Stall_Out, Done_Out, Load_Out, Error_Out;
   logic [31:0] RData_Out;

   typedef struct {
      logic        done;
      logic        load;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   dmem_access_ctrl #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(15)
   ) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .Enable_In (Enable_In),
      .rw_In     (rw_In),
      .Size_In   (Size_In),
      .Load_In   (Load_In),
      .Address_In(Address_In),
      .WData_In  (WData_In),
      .mem_req   (mem_req),
      .mem_rw    (mem_rw),
      .mem_size  (mem_size),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .Stall_Out (Stall_Out),
      .Done_Out  (Done_Out),
      .Load_Out  (Load_Out),
      .RData_Out (RData_Out),
      .Error_Out (Error_Out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Completion monitor: every Done/Error pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (!CLR && (Done_Out || Error_Out)) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_evt", {30'h0, Done_Out, Error_Out}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("evt_done", {31'h0, Done_Out}, {31'h0, e.done});
            check_eq("evt_load", {31'h0, Load_Out}, {31'h0, e.load});
            check_eq("evt_err", {31'h0, Error_Out}, {31'h0, e.err});
            if (e.done) check_eq("evt_rdata", RData_Out, e.rdata);
         end
      end
   end

   // lat = BUSY cycle in which ready is raised; 0 means never (timeout).
   task automatic access(input string tag, input logic rw, input logic size, input logic load,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat,
                         input int exp_stall, input int exp_req);
      exp_t e;
      int   stalls = 0;
      int   reqs   = 0;
      int   bc     = 0;
      bit   done   = 0;
      bit   tmo;
      tmo     = (lat == 0);
      e.done  = 1'b1;
      e.load  = load & ~tmo;
      e.err   = tmo;
      if (tmo || rw) e.rdata = 32'h0;
      else if (size) e.rdata = {24'h0, rdata[7:0]};
      else           e.rdata = rdata;
      @(negedge CLK);
      sb.push_back(e);
      Enable_In  = 1'b1;
      rw_In      = rw;
      Size_In    = size;
      Load_In    = load;
      Address_In = addr;
      WData_In   = wdata;
      mem_rdata  = rdata;
      for (int i = 0; i < 40 && !done; i++) begin
         #1;
         if (Done_Out) begin
            done = 1;
            check_eq({tag, "_done_stall"}, {31'h0, Stall_Out}, 32'h0);
         end else begin
            if (Stall_Out) stalls++;
            if (mem_req) begin
               reqs++;
               bc++;
               if (bc == 1) begin
                  check_eq({tag, "_addr"}, mem_addr, addr);
                  check_eq({tag, "_rw"}, {31'h0, mem_rw}, {31'h0, rw});
                  check_eq({tag, "_size"}, {31'h0, mem_size}, {31'h0, size});
                  check_eq({tag, "_wdata"}, mem_wdata, wdata);
               end
            end
            mem_ready = mem_req && (bc == lat);
            @(negedge CLK);
         end
      end
      Enable_In = 1'b0;
      mem_ready = 1'b0;
      check_eq({tag, "_completed"}, {31'h0, done}, 32'h1);
      check_eq({tag, "_stall_cycles"}, stalls, exp_stall);
      check_eq({tag, "_req_cycles"}, reqs, exp_req);
   endtask

   task automatic misaligned(input logic [31:0] addr);
      exp_t e;
      e.done  = 1'b0;
      e.load  = 1'b0;
      e.err   = 1'b1;
      e.rdata = 32'h0;
      @(negedge CLK);
      sb.push_back(e);
      Enable_In  = 1'b1;
      rw_In      = 1'b0;
      Size_In    = 1'b0;
      Load_In    = 1'b1;
      Address_In = addr;
      #1;
      check_eq("mis_stall", {31'h0, Stall_Out}, 32'h0);
      check_eq("mis_err_early", {31'h0, Error_Out}, 32'h0);
      @(negedge CLK);
      Enable_In = 1'b0;
      #1;
      check_eq("mis_err_pulse", {31'h0, Error_Out}, 32'h1);
      check_eq("mis_req", {31'h0, mem_req}, 32'h0);
      @(negedge CLK);
      #1;
      check_eq("mis_err_one_cycle", {31'h0, Error_Out}, 32'h0);
      check_eq("mis_req_after", {31'h0, mem_req}, 32'h0);
   endtask

   task automatic reset_mid_access();
      @(negedge CLK);
      Enable_In  = 1'b1;
      rw_In      = 1'b1;
      Size_In    = 1'b1;
      Load_In    = 1'b0;
      Address_In = 32'h300;
      WData_In   = 32'h55AA55AA;
      @(negedge CLK);
      #1;
      check_eq("rst_busy1_req", {31'h0, mem_req}, 32'h1);
      @(negedge CLK);
      #1;
      CLR       = 1'b1;
      Enable_In = 1'b0;
      #1;
      check_eq("rst_req", {31'h0, mem_req}, 32'h0);
      check_eq("rst_rw_size", {30'h0, mem_rw, mem_size}, 32'h0);
      check_eq("rst_addr", mem_addr, 32'h0);
      check_eq("rst_wdata", mem_wdata, 32'h0);
      check_eq("rst_flags", {28'h0, Stall_Out, Done_Out, Load_Out, Error_Out}, 32'h0);
      check_eq("rst_rdata", RData_Out, 32'h0);
      repeat (2) @(negedge CLK);
      CLR = 1'b0;
   endtask

   initial begin
      CLR        = 1'b1;
      Enable_In  = 1'b0;
      rw_In      = 1'b0;
      Size_In    = 1'b0;
      Load_In    = 1'b0;
      Address_In = 32'h0;
      WData_In   = 32'h0;
      mem_rdata  = 32'h0;
      mem_ready  = 1'b0;
      #2;
      check_eq("reset_req", {31'h0, mem_req}, 32'h0);
      check_eq("reset_outs", {28'h0, Stall_Out, Done_Out, Load_Out, Error_Out}, 32'h0);
      check_eq("reset_addr", mem_addr, 32'h0);
      check_eq("reset_rdata", RData_Out, 32'h0);
      @(negedge CLK);
      CLR = 1'b0;

      access("wload", 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1, 2, 1);
      access("bload", 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 32'h123456A5, 3, 4, 3);
      access("wstore", 1'b1, 1'b0, 1'b0, 32'h200, 32'hCAFEF00D, 32'h11111111, 2, 3, 2);
      misaligned(32'h102);
      access("timeout", 1'b0, 1'b0, 1'b1, 32'h400, 32'h0, 32'h77777777, 0, 16, 15);
      access("late_ready", 1'b0, 1'b0, 1'b1, 32'h404, 32'h0, 32'h87654321, 15, 16, 15);
      reset_mid_access();
      access("post_reset", 1'b0, 1'b0, 1'b1, 32'h500, 32'h0, 32'h0BADF00D, 2, 3, 2);

      repeat (3) @(negedge CLK);
      check_eq("sb_drained", sb.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
